// File: rtl/vscpu_pkg.sv
// Shared constants and run-controller state encoding for the VerySimpleCPU subsystem.
package vscpu_pkg;

    localparam int unsigned VSCPU_ADDR_W = 14;
    localparam int unsigned VSCPU_DATA_W = 32;

    localparam logic [VSCPU_ADDR_W-1:0] VSCPU_HALT_ADDR = 14'h3FFF;

    typedef logic [1:0] vscpu_state_t;

    localparam vscpu_state_t StIdle = 2'd0;
    localparam vscpu_state_t StLoad = 2'd1;
    localparam vscpu_state_t StRun  = 2'd2;
    localparam vscpu_state_t StDone = 2'd3;

endpackage

// File: rtl/vscpu_boot_ctrl_if.sv
// Host-side bundle of the boot controller: run start, program load stream and RAM read port.
interface vscpu_boot_ctrl_if
    import vscpu_pkg::*;
#(
    parameter int unsigned SIZE = VSCPU_ADDR_W
);

    logic                    start;
    logic                    skip_load;

    logic                    ld_valid;
    logic                    ld_ready;
    logic [VSCPU_DATA_W-1:0] ld_data;
    logic                    ld_last;

    logic                    rd_req;
    logic [SIZE-1:0]         rd_addr;
    logic                    rd_valid;
    logic [VSCPU_DATA_W-1:0] rd_data;

    // Host / loader side
    modport master (
        output start, skip_load, ld_valid, ld_data, ld_last, rd_req, rd_addr,
        input  ld_ready, rd_valid, rd_data
    );

    // Boot controller side
    modport slave (
        input  start, skip_load, ld_valid, ld_data, ld_last, rd_req, rd_addr,
        output ld_ready, rd_valid, rd_data
    );

endinterface

// File: rtl/vscpu_wdog.sv
// Run watchdog: counts enabled cycles since the last clear and flags the cycle that reaches LIMIT.
module vscpu_wdog #(
    parameter int unsigned     WIDTH = 24,
    parameter logic [WIDTH-1:0] LIMIT = '1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic hit
);

    // The flag fires during the LIMIT-th enabled cycle, i.e. after LIMIT-1 increments.
    localparam logic [WIDTH-1:0] LastCount = LIMIT - WIDTH'(1);

    logic [WIDTH-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (enable) begin
            cnt_q <= cnt_q + WIDTH'(1);
        end
    end

    assign hit = enable && (cnt_q == LastCount);

endmodule

// File: rtl/vscpu_boot_ctrl.sv
// Run controller: loads the program into RAM, runs the CPU until a halt-mailbox write, then
// serves host reads. Define VSCPU_WATCHDOG_EN to build the RUN-phase timeout watchdog.
module vscpu_boot_ctrl
    import vscpu_pkg::*;
#(
    parameter int unsigned       SIZE       = VSCPU_ADDR_W,
    parameter logic [SIZE-1:0]   LOAD_BASE  = '0,
    parameter logic [SIZE-1:0]   HALT_ADDR  = VSCPU_HALT_ADDR,
    parameter int unsigned       WDOG_W     = 24,
    parameter logic [WDOG_W-1:0] WDOG_LIMIT = 24'hFF_FFFF
) (
    input  logic                    clk,
    input  logic                    rst_n,

    vscpu_boot_ctrl_if.slave        host,

    output logic                    cpu_rst,
    input  logic                    cpu_wrEn,
    input  logic [SIZE-1:0]         cpu_addr,
    input  logic [VSCPU_DATA_W-1:0] cpu_data,

    output logic                    ram_wrEn,
    output logic [SIZE-1:0]         ram_addr,
    output logic [VSCPU_DATA_W-1:0] ram_wdata,
    input  logic [VSCPU_DATA_W-1:0] ram_rdata,

    output logic                    busy,
    output logic                    halted,
    output logic                    timeout,
    output logic [VSCPU_DATA_W-1:0] result
);

    vscpu_state_t            state_q, state_d;
    logic [SIZE-1:0]         load_cnt_q, load_cnt_d;
    logic                    cpu_rst_q;
    logic                    rd_valid_q;
    logic                    halted_q;
    logic                    timeout_q;
    logic [VSCPU_DATA_W-1:0] result_q;

    logic in_run;
    logic idle_like;
    logic go;
    logic ld_fire;
    logic rd_fire;
    logic halt_hit;
    logic wdog_hit;

    assign in_run    = (state_q == StRun);
    assign idle_like = (state_q == StIdle) || (state_q == StDone);
    assign go        = idle_like && host.start;
    assign ld_fire   = (state_q == StLoad) && host.ld_valid;
    // start takes priority over a read in the same cycle
    assign rd_fire   = idle_like && host.rd_req && !host.start;
    assign halt_hit  = in_run && cpu_wrEn && (cpu_addr == HALT_ADDR);

`ifdef VSCPU_WATCHDOG_EN
    logic wdog_clear;

    assign wdog_clear = !in_run;

    vscpu_wdog #(
        .WIDTH (WDOG_W),
        .LIMIT (WDOG_LIMIT)
    ) u_wdog (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (wdog_clear),
        .enable (in_run),
        .hit    (wdog_hit)
    );
`else
    logic unused_wdog;

    assign unused_wdog = ^{WDOG_LIMIT, WDOG_W};
    assign wdog_hit    = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        load_cnt_d = load_cnt_q;
        case (state_q)
            StIdle, StDone: begin
                if (host.start) begin
                    if (host.skip_load) begin
                        state_d = StRun;
                    end else begin
                        state_d    = StLoad;
                        load_cnt_d = '0;
                    end
                end
            end
            StLoad: begin
                if (host.ld_valid) begin
                    load_cnt_d = load_cnt_q + SIZE'(1);
                    if (host.ld_last) begin
                        state_d = StRun;
                    end
                end
            end
            StRun: begin
                if (halt_hit || wdog_hit) begin
                    state_d = StDone;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            load_cnt_q <= '0;
            cpu_rst_q  <= 1'b1;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            load_cnt_q <= load_cnt_d;
            // CPU leaves reset exactly in the first RUN cycle
            cpu_rst_q  <= (state_d != StRun);
            rd_valid_q <= rd_fire;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            halted_q  <= 1'b0;
            timeout_q <= 1'b0;
            result_q  <= '0;
        end else if (go && !host.skip_load) begin
            halted_q  <= 1'b0;
            timeout_q <= 1'b0;
            result_q  <= '0;
        end else if (halt_hit) begin
            halted_q <= 1'b1;
            result_q <= cpu_data;
        end else if (wdog_hit) begin
            timeout_q <= 1'b1;
        end
    end

    // RAM port mux; in RUN the halt-mailbox write still reaches RAM
    always_comb begin
        ram_wrEn  = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        if (ld_fire) begin
            ram_wrEn  = 1'b1;
            ram_addr  = LOAD_BASE + load_cnt_q;
            ram_wdata = host.ld_data;
        end else if (in_run) begin
            ram_wrEn  = cpu_wrEn;
            ram_addr  = cpu_addr;
            ram_wdata = cpu_data;
        end else if (rd_fire) begin
            ram_addr = host.rd_addr;
        end
    end

    assign host.ld_ready = (state_q == StLoad);
    assign host.rd_valid = rd_valid_q;
    assign host.rd_data  = rd_valid_q ? ram_rdata : '0;

    assign cpu_rst = cpu_rst_q;
    assign busy    = (state_q == StLoad) || in_run;
    assign halted  = halted_q;
    assign timeout = timeout_q;
    assign result  = result_q;

endmodule

// File: tb/tb_vscpu_boot_ctrl.sv
// Directed self-checking bench for vscpu_boot_ctrl with a behavioural synchronous RAM.
module tb_vscpu_boot_ctrl;
    import vscpu_pkg::*;

    localparam int unsigned SIZE = 14;
    localparam logic [SIZE-1:0] HALT = 14'h3FFF;

    localparam logic [31:0] W0 = 32'hDEAD_0000;
    localparam logic [31:0] W1 = 32'h1111_2222;
    localparam logic [31:0] W2 = 32'hCAFE_0002;
    localparam logic [31:0] W3 = 32'h0BAD_F00D;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    vscpu_boot_ctrl_if #(.SIZE(SIZE)) host ();

    logic            cpu_rst;
    logic            cpu_wrEn;
    logic [SIZE-1:0] cpu_addr;
    logic [31:0]     cpu_data;
    logic            ram_wrEn;
    logic [SIZE-1:0] ram_addr;
    logic [31:0]     ram_wdata;
    logic [31:0]     ram_rdata;
    logic            busy;
    logic            halted;
    logic            timeout;
    logic [31:0]     result;

    int n_checks = 0;
    int n_fail = 0;

    logic [31:0] mem [2**SIZE];

    always @(posedge clk) begin
        if (ram_wrEn) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    vscpu_boot_ctrl #(
        .SIZE       (SIZE),
        .LOAD_BASE  (14'd0),
        .HALT_ADDR  (HALT),
        .WDOG_W     (24),
        .WDOG_LIMIT (24'd16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .host      (host),
        .cpu_rst   (cpu_rst),
        .cpu_wrEn  (cpu_wrEn),
        .cpu_addr  (cpu_addr),
        .cpu_data  (cpu_data),
        .ram_wrEn  (ram_wrEn),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata),
        .busy      (busy),
        .halted    (halted),
        .timeout   (timeout),
        .result    (result)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic check_reset_vals(input string pfx);
        check_eq({pfx, "_cpu_rst"},  32'(cpu_rst),       32'd1);
        check_eq({pfx, "_ld_ready"}, 32'(host.ld_ready), 32'd0);
        check_eq({pfx, "_rd_valid"}, 32'(host.rd_valid), 32'd0);
        check_eq({pfx, "_rd_data"},  host.rd_data,       32'd0);
        check_eq({pfx, "_busy"},     32'(busy),          32'd0);
        check_eq({pfx, "_halted"},   32'(halted),        32'd0);
        check_eq({pfx, "_timeout"},  32'(timeout),       32'd0);
        check_eq({pfx, "_result"},   result,             32'd0);
        check_eq({pfx, "_ram_wren"}, 32'(ram_wrEn),      32'd0);
        check_eq({pfx, "_ram_addr"}, 32'(ram_addr),      32'd0);
        check_eq({pfx, "_ram_wdat"}, ram_wdata,          32'd0);
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    initial begin
        host.start     = 1'b0;
        host.skip_load = 1'b0;
        host.ld_valid  = 1'b0;
        host.ld_data   = '0;
        host.ld_last   = 1'b0;
        host.rd_req    = 1'b0;
        host.rd_addr   = '0;
        cpu_wrEn       = 1'b0;
        cpu_addr       = '0;
        cpu_data       = '0;

        #12;
        check_reset_vals("por");
        @(negedge clk);
        rst_n = 1'b1;

        // Load three words, ld_valid held, last on the third
        tick(); host.start = 1'b1;
        mid();
        tick(); host.start = 1'b0; host.ld_valid = 1'b1; host.ld_data = W0;
        mid();
        check_eq("ld0_ready", 32'(host.ld_ready), 32'd1);
        check_eq("ld0_wren",  32'(ram_wrEn),      32'd1);
        check_eq("ld0_addr",  32'(ram_addr),      32'd0);
        check_eq("ld0_wdata", ram_wdata,          W0);
        check_eq("ld0_busy",  32'(busy),          32'd1);
        tick(); host.ld_data = W1;
        mid();
        check_eq("ld1_addr",  32'(ram_addr),      32'd1);
        check_eq("ld1_wdata", ram_wdata,          W1);
        tick(); host.ld_data = W2; host.ld_last = 1'b1;
        mid();
        check_eq("ld2_addr",    32'(ram_addr), 32'd2);
        check_eq("ld2_cpu_rst", 32'(cpu_rst),  32'd1);
        tick(); host.ld_valid = 1'b0; host.ld_last = 1'b0;
        mid();
        check_eq("run_cpu_rst",  32'(cpu_rst),       32'd0);
        check_eq("run_ld_ready", 32'(host.ld_ready), 32'd0);
        check_eq("run_busy",     32'(busy),          32'd1);

        // RUN pass-through, with a host read that must be dropped
        tick(); cpu_wrEn = 1'b1; cpu_addr = 14'd5; cpu_data = 32'd77;
        host.rd_req = 1'b1; host.rd_addr = 14'd1;
        mid();
        check_eq("pass_wren",  32'(ram_wrEn), 32'd1);
        check_eq("pass_addr",  32'(ram_addr), 32'd5);
        check_eq("pass_wdata", ram_wdata,     32'd77);
        tick(); host.rd_req = 1'b0; cpu_addr = HALT; cpu_data = 32'h2A;
        mid();
        check_eq("rd_in_run",  32'(host.rd_valid), 32'd0);
        check_eq("halt_fwd_w", 32'(ram_wrEn),      32'd1);
        check_eq("halt_fwd_a", 32'(ram_addr),      32'(HALT));
        tick(); cpu_wrEn = 1'b0;
        mid();
        check_eq("halt_cpu_rst", 32'(cpu_rst), 32'd1);
        check_eq("halt_flag",    32'(halted),  32'd1);
        check_eq("halt_result",  result,       32'h2A);
        check_eq("halt_timeout", 32'(timeout), 32'd0);
        check_eq("halt_busy",    32'(busy),    32'd0);

        // Reads in DONE: single then back-to-back
        tick(); host.rd_req = 1'b1; host.rd_addr = 14'd1;
        mid();
        check_eq("rd_addr_out", 32'(ram_addr), 32'd1);
        check_eq("rd_wren",     32'(ram_wrEn), 32'd0);
        tick(); host.rd_addr = 14'd0;
        mid();
        check_eq("rd1_valid", 32'(host.rd_valid), 32'd1);
        check_eq("rd1_data",  host.rd_data,       W1);
        tick(); host.rd_addr = 14'd2;
        mid();
        check_eq("rd0_data", host.rd_data, W0);
        tick(); host.rd_req = 1'b0;
        mid();
        check_eq("rd2_data", host.rd_data, W2);
        tick();
        mid();
        check_eq("rd_idle_valid", 32'(host.rd_valid), 32'd0);

        // start and rd_req together: start wins, read dropped
        tick(); host.start = 1'b1; host.rd_req = 1'b1; host.rd_addr = 14'd1;
        mid();
        check_eq("st_rd_addr", 32'(ram_addr), 32'd0);
        tick(); host.start = 1'b0; host.rd_req = 1'b0;
        mid();
        check_eq("st_rd_valid", 32'(host.rd_valid), 32'd0);
        check_eq("st_busy",     32'(busy),          32'd1);
        check_eq("st_ld_ready", 32'(host.ld_ready), 32'd1);
        check_eq("st_halt_clr", 32'(halted),        32'd0);
        check_eq("st_res_clr",  result,             32'd0);

        // Reset in the middle of a load after two words
        tick(); host.ld_valid = 1'b1; host.ld_data = 32'h1234_5678;
        mid();
        tick(); host.ld_data = 32'h9ABC_DEF0;
        mid();
        check_eq("mid_ld_addr", 32'(ram_addr), 32'd1);
        tick(); host.ld_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check_reset_vals("rst_ld");
        @(negedge clk);
        rst_n = 1'b1;

        // skip_load goes straight to RUN with no RAM writes
        tick(); host.start = 1'b1; host.skip_load = 1'b1;
        mid();
        check_eq("skip_wren0", 32'(ram_wrEn), 32'd0);
        tick(); host.start = 1'b0; host.skip_load = 1'b0;
        mid();
        check_eq("skip_busy",    32'(busy),          32'd1);
        check_eq("skip_cpu_rst", 32'(cpu_rst),       32'd0);
        check_eq("skip_ld_rdy",  32'(host.ld_ready), 32'd0);
        check_eq("skip_wren1",   32'(ram_wrEn),      32'd0);
        tick(); cpu_wrEn = 1'b1; cpu_addr = HALT; cpu_data = 32'h55;
        mid();
        tick(); cpu_wrEn = 1'b0;
        mid();
        check_eq("skip_halted", 32'(halted),  32'd1);
        check_eq("skip_result", result,       32'h55);
        check_eq("skip_cpurst", 32'(cpu_rst), 32'd1);

`ifdef VSCPU_WATCHDOG_EN
        // Looping program: timeout after exactly 16 RUN cycles
        tick(); host.start = 1'b1;
        mid();
        tick(); host.start = 1'b0; host.ld_valid = 1'b1; host.ld_last = 1'b1; host.ld_data = W3;
        mid();
        tick(); host.ld_valid = 1'b0; host.ld_last = 1'b0;
        for (int i = 0; i < 15; i++) begin
            mid();
            tick();
        end
        mid();
        check_eq("wd_busy_16", 32'(busy), 32'd1);
        tick();
        mid();
        check_eq("wd_timeout", 32'(timeout), 32'd1);
        check_eq("wd_halted",  32'(halted),  32'd0);
        check_eq("wd_busy",    32'(busy),    32'd0);
        check_eq("wd_cpu_rst", 32'(cpu_rst), 32'd1);

        // Halt write lands on the limit cycle: halt wins
        tick(); host.start = 1'b1;
        mid();
        tick(); host.start = 1'b0; host.ld_valid = 1'b1; host.ld_last = 1'b1; host.ld_data = W3;
        mid();
        tick(); host.ld_valid = 1'b0; host.ld_last = 1'b0;
        for (int i = 0; i < 15; i++) begin
            mid();
            tick();
        end
        cpu_wrEn = 1'b1; cpu_addr = HALT; cpu_data = 32'h99;
        mid();
        tick(); cpu_wrEn = 1'b0;
        mid();
        check_eq("wdh_halted",  32'(halted),  32'd1);
        check_eq("wdh_timeout", 32'(timeout), 32'd0);
        check_eq("wdh_result",  result,       32'h99);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
